// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode classification for alu_multicycle.
// Optional divider support is selected by the ALU_DIV_EN macro.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for opcodes that run through the iterative unit.
  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between issue and writeback for alu_multicycle.
// master issues operations and takes results; slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] operand_A;
  logic [WIDTH-1:0] operand_B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, ALU_Control, operand_A, operand_B, out_ready,
    input  in_ready, out_valid, ALU_result, zero, overflow
  );

  modport slave (
    input  in_valid, ALU_Control, operand_A, operand_B, out_ready,
    output in_ready, out_valid, ALU_result, zero, overflow
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Shift-add multiplier (and restoring divider with ALU_DIV_EN): WIDTH iterations after start,
// done is combinational in the final iteration and result is the value written at that edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic [3:0]       op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  // acc: product / partial remainder; sreg: multiplier / quotient; opnd: multiplicand / divisor
  logic [WIDTH-1:0] acc, sreg, opnd;
  logic [WIDTH-1:0] acc_next, sreg_next, opnd_next;

`ifdef ALU_DIV_EN
  logic           div_q, rem_q;
  logic [WIDTH:0] partial, trial;
`endif

  assign done = (cnt == CNT_W'(1));

  always_comb begin
    acc_next  = acc;
    sreg_next = sreg;
    opnd_next = opnd;
`ifdef ALU_DIV_EN
    partial = {acc, sreg[WIDTH-1]};
    trial   = partial - {1'b0, opnd};
    if (div_q) begin
      // Divisor zero never restores, giving all-ones quotient and remainder == dividend.
      if (!trial[WIDTH]) begin
        acc_next  = trial[WIDTH-1:0];
        sreg_next = {sreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next  = partial[WIDTH-1:0];
        sreg_next = {sreg[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (sreg[0]) acc_next = acc + opnd;
      opnd_next = opnd << 1;
      sreg_next = sreg >> 1;
    end
  end

`ifdef ALU_DIV_EN
  assign result = (div_q && !rem_q) ? sreg_next : acc_next;
`else
  assign result = acc_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      acc  <= '0;
      sreg <= '0;
      opnd <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
      rem_q <= 1'b0;
`endif
    end else if (start) begin
      cnt <= CNT_W'(WIDTH);
      acc <= '0;
`ifdef ALU_DIV_EN
      div_q <= (op == ALU_DIVU) || (op == ALU_REMU);
      rem_q <= (op == ALU_REMU);
      if ((op == ALU_DIVU) || (op == ALU_REMU)) begin
        sreg <= a;
        opnd <= b;
      end else begin
        sreg <= b;
        opnd <= a;
      end
`else
      sreg <= b;
      opnd <= a;
`endif
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      acc  <= acc_next;
      sreg <= sreg_next;
      opnd <= opnd_next;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: logic ops out_valid 1 cycle after accept, MUL/DIVU/REMU (ALU_DIV_EN) after WIDTH+1;
// result held in DONE until out_ready, no new accept until then.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  alu_multicycle_if.slave bus
);

  state_t           state, state_next;
  logic             accept, start, iter_done;
  logic [WIDTH-1:0] a, b, sum, diff, sc_result, iter_result;
  logic             sc_ovf;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q;

  assign a            = bus.operand_A;
  assign b            = bus.operand_B;
  assign bus.in_ready = (state == S_IDLE);
  assign accept       = bus.in_valid && (state == S_IDLE);
  assign start        = accept && is_iter(bus.ALU_Control);
  assign sum          = a + b;
  assign diff         = a - b;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (bus.ALU_Control)
      ALU_AND: sc_result = a & b;
      ALU_OR:  sc_result = a | b;
      ALU_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: sc_result = ~(a | b);
      ALU_MUL, ALU_DIVU, ALU_REMU: sc_result = '0;
      default: sc_result = '0;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
`ifdef ALU_DIV_EN
    .op     (bus.ALU_Control),
`endif
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_iter(bus.ALU_Control) ? S_BUSY : S_DONE;
      S_BUSY: if (iter_done) state_next = S_DONE;
      S_DONE: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_iter(bus.ALU_Control)) begin
        result_q <= sc_result;
        zero_q   <= (sc_result == '0);
        ovf_q    <= sc_ovf;
      end else if ((state == S_BUSY) && iter_done) begin
        result_q <= iter_result;
        zero_q   <= (iter_result == '0);
        ovf_q    <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = (state == S_DONE);
  assign bus.ALU_result = result_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Reference built straight from the opcode definitions with wide integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output int lat);
    longint      sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ov = 1'b0; lat = 1;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_ADD: begin s = sa + sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      ALU_SUB: begin s = sa - sb; r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      ALU_MUL: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = W + 1; end
`ifdef ALU_DIV_EN
      ALU_DIVU: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = W + 1; end
      ALU_REMU: begin r = (b == 0) ? a : a % b; lat = W + 1; end
`endif
      default: r = '0;
    endcase
  endfunction

  // Issue one op at a negedge, scramble inputs after accept, wait for result, stall, then pop.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall,
                       output logic [31:0] r, output logic z, output logic ov, output int lat);
    bus.in_valid = 1'b1; bus.ALU_Control = op; bus.operand_A = a; bus.operand_B = b;
    @(posedge clock); @(negedge clock);
    bus.in_valid = 1'b0;
    bus.ALU_Control = 4'($urandom); bus.operand_A = $urandom; bus.operand_B = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(negedge clock); lat++; end
    if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    repeat (stall) @(negedge clock);
    r = bus.ALU_result; z = bus.zero; ov = bus.overflow;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, er;
    logic        z, ov, eov;
    int          lat, elat, bad, n;
    logic [3:0]  ops [11];

    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_DIVU, ALU_REMU, 4'b0011, 4'b1111};

    vecs.push_back('{ALU_ADD, 32'd5,          32'd7,          32'd12,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SUB, 32'd10,         32'd4,          32'd6,           1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SUB, 32'd4,          32'd4,          32'd0,           1'b1, 1'b0, 1});
    vecs.push_back('{ALU_SLT, 32'd2,          32'd4,          32'd1,           1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,           1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SLT, 32'd4,          32'd2,          32'd0,           1'b1, 1'b0, 1});
    vecs.push_back('{ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,   1'b0, 1'b1, 1});
    vecs.push_back('{ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,   1'b0, 1'b1, 1});
    vecs.push_back('{ALU_NOR, 32'd2,          32'd4,          32'hFFFF_FFF9,   1'b0, 1'b0, 1});
    vecs.push_back('{ALU_OR,  32'h0F00,       32'h00F0,       32'h0FF0,        1'b0, 1'b0, 1});
    vecs.push_back('{4'b0011, 32'd9,          32'd9,          32'd0,           1'b1, 1'b0, 1});
    vecs.push_back('{ALU_MUL, 32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF,   1'b0, 1'b0, 33});
    vecs.push_back('{ALU_MUL, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,   1'b0, 1'b0, 33});
`ifdef ALU_DIV_EN
    vecs.push_back('{ALU_DIVU, 32'd100,       32'd7,          32'd14,          1'b0, 1'b0, 33});
    vecs.push_back('{ALU_REMU, 32'd100,       32'd7,          32'd2,           1'b0, 1'b0, 33});
    vecs.push_back('{ALU_DIVU, 32'd5,         32'd0,          32'hFFFF_FFFF,   1'b0, 1'b0, 33});
    vecs.push_back('{ALU_REMU, 32'd5,         32'd0,          32'd5,           1'b0, 1'b0, 33});
`else
    vecs.push_back('{ALU_DIVU, 32'd100,       32'd7,          32'd0,           1'b1, 1'b0, 1});
    vecs.push_back('{ALU_REMU, 32'd100,       32'd7,          32'd0,           1'b1, 1'b0, 1});
`endif

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ALU_Control = '0; bus.operand_A = '0; bus.operand_B = '0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.ALU_result,     32'd0);
    check("rst_zero",      32'(bus.zero),      32'd1);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, z, ov, lat);
      check($sformatf("vec%0d_result", i),   r,          vecs[i].res);
      check($sformatf("vec%0d_zero", i),     32'(z),     32'(vecs[i].z));
      check($sformatf("vec%0d_overflow", i), 32'(ov),    32'(vecs[i].ov));
      check($sformatf("vec%0d_latency", i),  32'(lat),   32'(vecs[i].lat));
    end

    // MUL with a competing request held during BUSY and DONE.
    bus.in_valid = 1'b1; bus.ALU_Control = ALU_MUL; bus.operand_A = 32'h0000_FFFF; bus.operand_B = 32'h0001_0001;
    @(posedge clock); @(negedge clock);
    bus.ALU_Control = ALU_ADD; bus.operand_A = 32'd1; bus.operand_B = 32'd1;
    bad = 0; n = 1;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) bad++;
      @(negedge clock); n++;
    end
    check("busy_in_ready_low", 32'(bad), 32'd0);
    check("busy_latency",      32'(n),   32'd33);
    check("done_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("busy_result",       bus.ALU_result, 32'hFFFF_FFFF);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("busy_no_extra_accept", 32'(bus.out_valid), 32'd0);
    check("busy_back_to_idle",    32'(bus.in_ready),  32'd1);

    // Backpressure: result must hold while out_ready stays low.
    bus.in_valid = 1'b1; bus.ALU_Control = ALU_AND; bus.operand_A = 32'hF0; bus.operand_B = 32'h3C;
    @(posedge clock); @(negedge clock);
    bus.in_valid = 1'b0; bus.operand_A = 32'hFFFF; bus.operand_B = 32'hFFFF;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!bus.out_valid || bus.ALU_result != 32'h30 || bus.in_ready) bad++;
      @(negedge clock);
    end
    check("bp_hold_bad_cycles", 32'(bad), 32'd0);
    check("bp_result",          bus.ALU_result, 32'h30);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1; bus.ALU_Control = ALU_MUL; bus.operand_A = 32'd3; bus.operand_B = 32'd5;
    @(posedge clock); @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result",    bus.ALU_result,     32'd0);
    check("midrst_zero",      32'(bus.zero),      32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    do_op(ALU_ADD, 32'd1, 32'd1, 0, r, z, ov, lat);
    check("midrst_add_result",  r,        32'd2);
    check("midrst_add_latency", 32'(lat), 32'd1);

    for (int i = 0; i < 250; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = '0; end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
          b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
        end
      endcase
      model(op, a, b, er, eov, elat);
      do_op(op, a, b, $urandom_range(0, 2), r, z, ov, lat);
      check($sformatf("rnd%0d_op%0h_result", i, op), r,        er);
      check($sformatf("rnd%0d_zero", i),             32'(z),   32'(er == 32'd0));
      check($sformatf("rnd%0d_overflow", i),         32'(ov),  32'(eov));
      check($sformatf("rnd%0d_latency", i),          32'(lat), 32'(elat));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle ALU: WIDTH-bit datapath with registered outputs and valid/ready handshakes on both sides.
- Adds an iterative shift-add multiplier, a signed-overflow flag and an optional restoring divider.
- Sits between the decode/issue stage and writeback in the project-1 datapath.
- Keeps the existing 4-bit ALU_Control encoding for the single-cycle operations.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
ALU_Control  input  4  opcode, sampled on accept
operand_A  input  WIDTH  first operand, sampled on accept
operand_B  input  WIDTH  second operand, sampled on accept
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
ALU_result  output  WIDTH  result, registered
zero  output  1  ALU_result == 0, registered
overflow  output  1  signed overflow (ADD/SUB only, else 0), registered

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR: single-cycle class.
  - 1000 MUL: low WIDTH bits of A*B.
  - 1001 DIVU, 1010 REMU: only with ALU_DIV_EN.
  - Any other code gives result 0, zero=1, overflow=0, single-cycle class.
- Accept: in_valid && in_ready at a rising edge. The opcode and operands are captured internally. Later input changes have no effect.
- in_ready = (state==IDLE). It is combinational from state only.
- States:
  - IDLE: on accept, go to DONE (single-cycle class) or BUSY (MUL/DIVU/REMU). The iteration counter loads WIDTH.
  - BUSY: one iteration per cycle; counter decrements. When counter reaches 1, write the result and go to DONE.
  - DONE: out_valid=1. Outputs hold stable while out_ready=0. On out_valid && out_ready, go to IDLE.
- Latency from accept edge N:
  - Single-cycle class: out_valid at N+1.
  - MUL/DIV: out_valid at N+WIDTH+1.
  - Throughput is at most one op per 2 cycles; no accept while in DONE.
- ADD/SUB:
  - Modulo 2^WIDTH.
  - overflow = operand signs such that the result sign is wrong. ADD: A,B same sign and result differs. SUB: A,B differ and result sign differs from A.
- MUL: unsigned shift-add over WIDTH iterations. The low-WIDTH product is also correct for signed operands.
- zero and overflow update in the same cycle as ALU_result.
- Reset, at any time including mid-BUSY or in DONE:
  - State goes to IDLE and the counter clears.
  - ALU_result=0, zero=1, overflow=0, out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
- in_valid held high while the block is not ready is simply not accepted. No error is raised.
- out_ready asserted while out_valid=0 is ignored.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined:
  - 1001 DIVU gives the quotient; 1010 REMU gives the remainder. Both are unsigned restoring division over WIDTH cycles in BUSY, sharing the multiplier's accumulator/shift registers.
  - Divide by zero: DIVU result all ones, REMU result operand_A. Same latency as a normal divide. overflow=0.
- Undefined: 1001/1010 behave as undefined opcodes (result 0, single-cycle). No divider logic is synthesised.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_DIVU, ALU_REMU).
  - State encoding (S_IDLE, S_BUSY, S_DONE).
- One sub-module, alu_iter_unit: iterative multiply/divide datapath. It holds the accumulator, shift registers and counter, with start/done pulses. The top holds the FSM, the single-cycle logic and the output registers.

Test Plan:
- WIDTH=32, ADD 5+7 -> ALU_result=12, zero=0, overflow=0, out_valid 1 cycle after accept. SUB 10-4 -> 6. SUB 4-4 -> 0, zero=1.
- SLT A=2,B=4 -> 1; SLT A=0xFFFF_FFFF,B=1 -> 1; ADD 0x7FFF_FFFF+1 -> 0x8000_0000, overflow=1; NOR 2,4 -> 0xFFFF_FFF9.
- MUL 0x0000_FFFF*0x0001_0001 -> 0xFFFF_FFFF, out_valid exactly 33 cycles after accept. in_ready=0 throughout BUSY/DONE. A second in_valid during BUSY is not accepted.
- Backpressure: hold out_ready=0 for 5 cycles after AND 0xF0,0x3C -> 0x30 held stable with out_valid=1. Release out_ready -> in_ready=1 next cycle.
- Assert reset at cycle 10 of a MUL -> next cycle out_valid=0, ALU_result=0, zero=1. A following ADD 1+1 returns 2 with normal latency.
- With ALU_DIV_EN: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 5/0 -> 0xFFFF_FFFF, REMU 5/0 -> 5. Without the macro: DIVU 100/7 -> 0, zero=1, 1-cycle latency.
